// File: rtl/worker_cpu_mult_pkg.sv
// rtl/worker_cpu_mult_pkg.sv - shared types and constants for the multiply combine stage
//
// Purpose : constants and the per-stage tag type used by worker_cpu_cpu_mult_combine
//           and worker_cpu_mult_hazard.
// Contents: DST_W  - register tag width
//           HALF_W - half-word width of the 16x16 partial products
//           tag_t  - {valid, dst} carried alongside each pipeline stage
package worker_cpu_mult_pkg;

  localparam int DST_W  = 5;
  localparam int HALF_W = 16;

  typedef struct packed {
    logic             valid;
    logic [DST_W-1:0] dst;
  } tag_t;

endpackage

// File: rtl/worker_cpu_mult_hazard.sv
// rtl/worker_cpu_mult_hazard.sv - read-after-write compare of decode sources against in-flight multiplies
//
// Purpose : purely combinational tag compare; raises stall when a decode source
//           matches the destination of a live multiply in A or M. Register 0 is
//           a hard zero and never causes a stall.
// Ports   : a_valid, a_dst       - A-stage tag
//           m_valid, m_flush,
//           m_dst                - M-stage tag and kill
//           src_a, src_b         - decode-stage source tags
//           stall                - hazard detected
module worker_cpu_mult_hazard #(
  parameter int DST_W = worker_cpu_mult_pkg::DST_W
) (
  input  logic             a_valid,
  input  logic [DST_W-1:0] a_dst,
  input  logic             m_valid,
  input  logic             m_flush,
  input  logic [DST_W-1:0] m_dst,
  input  logic [DST_W-1:0] src_a,
  input  logic [DST_W-1:0] src_b,
  output logic             stall
);

  logic a_hit;
  logic m_hit;

  always_comb begin
    a_hit = a_valid & (a_dst != '0) & ((a_dst == src_a) | (a_dst == src_b));
    // A multiply being killed this cycle will never write back, so it cannot hazard.
    m_hit = m_valid & ~m_flush & (m_dst != '0) & ((m_dst == src_a) | (m_dst == src_b));
    stall = a_hit | m_hit;
  end

endmodule

// File: rtl/worker_cpu_cpu_mult_combine.sv
// rtl/worker_cpu_cpu_mult_combine.sv - reduce three 16x16 partial products to the low 32 bits of a 32x32 product
//
// Purpose : two-stage pipeline (A, W) after the multiplier cell's M stage.
//           A keeps p1 and the 16-bit cross sum p2[15:0]+p3[15:0]; W adds the
//           cross sum into the upper half of p1. Upper halves of p2/p3 only
//           contribute to product bits 63:32 and are dropped.
// Config  : WORKER_CPU_MULT_HAZARD_EN - when defined, D_mul_stall is driven by
//           worker_cpu_mult_hazard; otherwise it is tied to 0.
// Ports   : clk, reset (async, active-high)
//           M_en, M_valid, M_dst, M_flush   - M-stage control and tag
//           M_mul_cell_p1/p2/p3             - registered partial products
//           D_src_a, D_src_b                - decode source tags
//           A_valid, A_dst                  - A-stage tag
//           W_valid, W_dst, W_mul_result    - final result (flop outputs)
//           D_mul_stall                     - decode hazard stall
module worker_cpu_cpu_mult_combine #(
  parameter int DST_W = worker_cpu_mult_pkg::DST_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_en,
  input  logic             M_valid,
  input  logic [DST_W-1:0] M_dst,
  input  logic             M_flush,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic [DST_W-1:0] D_src_a,
  input  logic [DST_W-1:0] D_src_b,
  output logic             A_valid,
  output logic [DST_W-1:0] A_dst,
  output logic             W_valid,
  output logic [DST_W-1:0] W_dst,
  output logic [31:0]      W_mul_result,
  output logic             D_mul_stall
);

  import worker_cpu_mult_pkg::*;

  logic [2*HALF_W-1:0] a_p1_q,     a_p1_d;
  logic [HALF_W-1:0]   a_cross_q,  a_cross_d;
  tag_t                a_tag_q,    a_tag_d;
  logic [2*HALF_W-1:0] w_result_q, w_result_d;
  tag_t                w_tag_q,    w_tag_d;

  always_comb begin
    a_p1_d     = a_p1_q;
    a_cross_d  = a_cross_q;
    a_tag_d    = a_tag_q;
    w_result_d = w_result_q;
    w_tag_d    = w_tag_q;

    if (M_en) begin
      a_p1_d        = M_mul_cell_p1;
      a_cross_d     = M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
      a_tag_d.valid = M_valid & ~M_flush;
      a_tag_d.dst   = M_dst;

      w_result_d    = {a_p1_q[2*HALF_W-1:HALF_W] + a_cross_q, a_p1_q[HALF_W-1:0]};
      // A flush coinciding with the W load is the only way W gets killed.
      w_tag_d.valid = a_tag_q.valid & ~M_flush;
      w_tag_d.dst   = a_tag_q.dst;
    end else if (M_flush) begin
      // Stalled flush: kill A only; W is already committed.
      a_tag_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p1_q     <= '0;
      a_cross_q  <= '0;
      a_tag_q    <= '0;
      w_result_q <= '0;
      w_tag_q    <= '0;
    end else begin
      a_p1_q     <= a_p1_d;
      a_cross_q  <= a_cross_d;
      a_tag_q    <= a_tag_d;
      w_result_q <= w_result_d;
      w_tag_q    <= w_tag_d;
    end
  end

  assign A_valid      = a_tag_q.valid;
  assign A_dst        = a_tag_q.dst;
  assign W_valid      = w_tag_q.valid;
  assign W_dst        = w_tag_q.dst;
  assign W_mul_result = w_result_q;

  logic unused_hi;
  assign unused_hi = ^{M_mul_cell_p2[31:HALF_W], M_mul_cell_p3[31:HALF_W]};

`ifdef WORKER_CPU_MULT_HAZARD_EN
  worker_cpu_mult_hazard #(
    .DST_W (DST_W)
  ) u_hazard (
    .a_valid (a_tag_q.valid),
    .a_dst   (a_tag_q.dst),
    .m_valid (M_valid),
    .m_flush (M_flush),
    .m_dst   (M_dst),
    .src_a   (D_src_a),
    .src_b   (D_src_b),
    .stall   (D_mul_stall)
  );
`else
  // Multiply hazards are resolved by pipeline control outside this block.
  assign D_mul_stall = 1'b0;

  logic unused_src;
  assign unused_src = ^{D_src_a, D_src_b};
`endif

endmodule

// File: tb/tb_worker_cpu_cpu_mult_combine.sv
// tb/tb_worker_cpu_cpu_mult_combine.sv - directed self-checking bench for worker_cpu_cpu_mult_combine
module tb_worker_cpu_cpu_mult_combine;

  localparam int DST_W = 5;

`ifdef WORKER_CPU_MULT_HAZARD_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             M_en;
  logic             M_valid;
  logic [DST_W-1:0] M_dst;
  logic             M_flush;
  logic [31:0]      M_mul_cell_p1;
  logic [31:0]      M_mul_cell_p2;
  logic [31:0]      M_mul_cell_p3;
  logic [DST_W-1:0] D_src_a;
  logic [DST_W-1:0] D_src_b;
  logic             A_valid;
  logic [DST_W-1:0] A_dst;
  logic             W_valid;
  logic [DST_W-1:0] W_dst;
  logic [31:0]      W_mul_result;
  logic             D_mul_stall;

  int compared   = 0;
  int mismatched = 0;

  worker_cpu_cpu_mult_combine #(.DST_W(DST_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .M_en          (M_en),
    .M_valid       (M_valid),
    .M_dst         (M_dst),
    .M_flush       (M_flush),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .D_src_a       (D_src_a),
    .D_src_b       (D_src_b),
    .A_valid       (A_valid),
    .A_dst         (A_dst),
    .W_valid       (W_valid),
    .W_dst         (W_dst),
    .W_mul_result  (W_mul_result),
    .D_mul_stall   (D_mul_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                      input logic [DST_W-1:0] dst, input logic vld);
    M_mul_cell_p1 = p1;
    M_mul_cell_p2 = p2;
    M_mul_cell_p3 = p3;
    M_dst         = dst;
    M_valid       = vld;
  endtask

  initial begin
    reset   = 1'b1;
    M_en    = 1'b0;
    M_flush = 1'b0;
    D_src_a = '0;
    D_src_b = '0;
    load(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();

    // reset state
    chk("rst_A_valid", A_valid, 0);
    chk("rst_A_dst", A_dst, 0);
    chk("rst_W_valid", W_valid, 0);
    chk("rst_W_dst", W_dst, 0);
    chk("rst_W_result", W_mul_result, 0);
    chk("rst_stall", D_mul_stall, 0);
    reset = 1'b0;

    // basic: 0x0001_0003 * 0x0002_0005 -> low word 0x000B_000F
    M_en = 1'b1;
    load(32'd15, 32'd6, 32'd5, 5'd4, 1'b1);
    tick();
    chk("basic_A_valid", A_valid, 1);
    chk("basic_A_dst", A_dst, 4);
    chk("basic_W_valid_early", W_valid, 0);
    M_valid = 1'b0;
    tick();
    chk("basic_result", W_mul_result, 32'h000B_000F);
    chk("basic_W_valid", W_valid, 1);
    chk("basic_W_dst", W_dst, 4);
    chk("basic_A_drained", A_valid, 0);

    // wrap: (-1)*(-1) partial products -> 1
    load(32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 5'd9, 1'b1);
    tick();
    M_valid = 1'b0;
    tick();
    chk("wrap_result", W_mul_result, 32'h0000_0001);
    chk("wrap_W_valid", W_valid, 1);
    chk("wrap_W_dst", W_dst, 9);

    // stall: multiply in A, M_en low for 3 edges
    load(32'h0001_0002, 32'h0000_0003, 32'h0000_0004, 5'd6, 1'b1);
    tick();
    chk("stall_load_A_valid", A_valid, 1);
    chk("stall_load_W_valid", W_valid, 0);
    M_en    = 1'b0;
    M_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_A_valid", A_valid, 1);
      chk("stall_A_dst", A_dst, 6);
      chk("stall_W_valid", W_valid, 0);
      chk("stall_W_result", W_mul_result, 32'h0000_0001);
      chk("stall_W_dst", W_dst, 9);
    end
    M_en = 1'b1;
    tick();
    chk("stall_result", W_mul_result, 32'h0008_0002);
    chk("stall_W_valid_out", W_valid, 1);
    chk("stall_W_dst_out", W_dst, 6);

    // flush with M_en=1: multiplies in M and A both killed
    load(32'h0000_0010, 32'h0, 32'h0, 5'd3, 1'b1);
    tick();
    chk("flush1_A_loaded", A_valid, 1);
    load(32'h0000_0020, 32'h0, 32'h0, 5'd5, 1'b1);
    M_flush = 1'b1;
    tick();
    chk("flush1_A_valid", A_valid, 0);
    chk("flush1_W_valid", W_valid, 0);
    M_flush = 1'b0;

    // flush with M_en=0: A killed, W keeps committed result
    load(32'h0000_0007, 32'h0000_0001, 32'h0000_0001, 5'd2, 1'b1);
    tick();
    load(32'h0000_0005, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    chk("flush0_pre_W_result", W_mul_result, 32'h0002_0007);
    chk("flush0_pre_A_valid", A_valid, 1);
    M_en    = 1'b0;
    M_valid = 1'b0;
    M_flush = 1'b1;
    tick();
    chk("flush0_A_valid", A_valid, 0);
    chk("flush0_W_valid", W_valid, 1);
    chk("flush0_W_result", W_mul_result, 32'h0002_0007);
    chk("flush0_W_dst", W_dst, 2);
    M_flush = 1'b0;
    M_en    = 1'b1;
    tick();
    chk("flush0_killed_no_W", W_valid, 0);

    // hazard compare
    load(32'h0, 32'h0, 32'h0, 5'd7, 1'b1);
    tick();
    M_en    = 1'b0;
    M_valid = 1'b0;
    D_src_b = 5'd7;
    #1;
    chk("hz_A_match", D_mul_stall, HZ);
    D_src_b = 5'd3;
    #1;
    chk("hz_A_nomatch", D_mul_stall, 0);
    M_en = 1'b1;
    load(32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
    tick();
    M_valid = 1'b0;
    D_src_a = 5'd0;
    D_src_b = 5'd0;
    #1;
    chk("hz_r0_no_stall", D_mul_stall, 0);
    M_en    = 1'b0;
    M_valid = 1'b1;
    M_dst   = 5'd5;
    D_src_a = 5'd5;
    #1;
    chk("hz_M_match", D_mul_stall, HZ);
    M_flush = 1'b1;
    #1;
    chk("hz_M_flushed", D_mul_stall, 0);
    M_flush = 1'b0;
    M_valid = 1'b0;
    D_src_a = 5'd0;

    // reset mid-stream with both stages valid
    M_en = 1'b1;
    load(32'h0000_0003, 32'h0, 32'h0, 5'd10, 1'b1);
    tick();
    load(32'h0000_0004, 32'h0, 32'h0, 5'd11, 1'b1);
    tick();
    chk("mid_pre_A_valid", A_valid, 1);
    chk("mid_pre_W_valid", W_valid, 1);
    M_valid = 1'b0;
    reset   = 1'b1;
    #1;
    chk("mid_A_valid", A_valid, 0);
    chk("mid_A_dst", A_dst, 0);
    chk("mid_W_valid", W_valid, 0);
    chk("mid_W_dst", W_dst, 0);
    chk("mid_W_result", W_mul_result, 0);
    chk("mid_stall", D_mul_stall, 0);
    tick();
    load(32'h0000_0009, 32'h0, 32'h0, 5'd12, 1'b1);
    reset = 1'b0;
    tick();
    chk("post_rst_W_valid_1", W_valid, 0);
    chk("post_rst_A_valid_1", A_valid, 1);
    tick();
    chk("post_rst_W_valid_2", W_valid, 1);
    chk("post_rst_W_result", W_mul_result, 32'h0000_0009);
    chk("post_rst_W_dst", W_dst, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
